// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor D = A - B - Bin, one 4-bit lookahead-borrow slice per clock.
// Start/Done handshake; operands captured on acceptance, result published on the final slice.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);

  localparam int NS = WIDTH / 4;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
  logic             borrow_reg;
  logic [KW-1:0]    k_reg;
  logic             busy_reg, done_reg, bout_reg, v_reg, z_reg;
  logic [WIDTH-1:0] d_reg;

  logic [3:0] a_nib, b_nib, g, p, diff;
  logic [4:0] bw;
  logic       last_slice;

  // Select the active nibble of the captured operands and merge its difference into the result.
  always_comb begin
    a_nib    = 4'd0;
    b_nib    = 4'd0;
    res_next = res_reg;
    for (int s = 0; s < NS; s++) begin
      if (k_reg == KW'(s)) begin
        a_nib = a_reg[4*s +: 4];
        b_nib = b_reg[4*s +: 4];
        res_next[4*s +: 4] = diff;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign g[gi]    = ~a_nib[gi] & b_nib[gi];
      assign p[gi]    = ~(a_nib[gi] ^ b_nib[gi]);
      assign diff[gi] = a_nib[gi] ^ b_nib[gi] ^ bw[gi];
    end
  endgenerate

  // Fully expanded lookahead: each borrow depends only on g/p and the slice borrow-in.
  assign bw[0] = borrow_reg;
  assign bw[1] = g[0] | (p[0] & bw[0]);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw[0]);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw[0]);
  assign bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bw[0]);

  assign last_slice = (k_reg == KW'(NS - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      k_reg      <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
      v_reg      <= 1'b0;
      z_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done_reg <= 1'b0;
          if (Start) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= Bin;
            res_reg    <= '0;
            k_reg      <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= S_RUN;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          res_reg    <= res_next;
          borrow_reg <= bw[4];
          k_reg      <= k_reg + 1'b1;
          if (last_slice) begin
            d_reg     <= res_next;
            bout_reg  <= bw[4];
            v_reg     <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (res_next[WIDTH-1] != a_reg[WIDTH-1]);
            z_reg     <= (res_next == '0);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_reg;
  assign Done = done_reg;
  assign D    = d_reg;
  assign Bout = bout_reg;
  assign V    = v_reg;
  assign Z    = z_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed checks for nibble_serial_subtractor (WIDTH=16): arithmetic, latency,
// handshake (ignored Start in RUN, back-to-back), and mid-operation reset.
module tb_nibble_serial_subtractor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [15:0] A, B;
  logic        Bin;
  logic        Busy, Done, Bout, V, Z;
  logic [15:0] D;

  int tests = 0;
  int fails = 0;
  int cyc;
  bit seen_done;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .Bin(Bin),
    .Busy(Busy), .Done(Done), .D(D), .Bout(Bout), .V(V), .Z(Z)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Issue one operation, wait (bounded) for Done, check latency and all result outputs.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [15:0] prev_d, input logic [15:0] ed,
                        input logic eb, input logic ev, input logic ez);
    Start = 1'b1; A = a; B = b; Bin = bin;
    step();
    Start = 1'b0; A = 16'hDEAD; B = 16'hBEEF; Bin = ~bin;
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    chk({tag, "_dhold"}, {16'd0, D}, {16'd0, prev_d});
    cyc = 0;
    while (!Done && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 32'd4);
    chk({tag, "_d"}, {16'd0, D}, {16'd0, ed});
    chk({tag, "_flags"}, {28'd0, Busy, Bout, V, Z}, {28'd0, 1'b0, eb, ev, ez});
    $display("[TB] %s A=%h B=%h Bin=%0d -> D=%h Bout=%0d V=%0d Z=%0d", tag, a, b, bin, D, Bout, V, Z);
    step();
    chk({tag, "_donepulse"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    step(); step();
    RST = 1'b0;
    chk("reset", {26'd0, Busy, Done, Bout, V, Z, |D}, 32'd0);

    run_op("basic",   16'h1234, 16'h0FFF, 1'b0, 16'h0000, 16'h0235, 1'b0, 1'b0, 1'b0);
    run_op("under",   16'h0000, 16'h0001, 1'b0, 16'h0235, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("ovf",     16'h8000, 16'h0001, 1'b0, 16'hFFFF, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("eqzero",  16'hABCD, 16'hABCD, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("eqbin",   16'hABCD, 16'hABCD, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("ripple",  16'h1000, 16'h0001, 1'b0, 16'hFFFF, 16'h0FFF, 1'b0, 1'b0, 1'b0);

    // Start held during RUN with changing operands: only the first are used.
    Start = 1'b1; A = 16'h0010; B = 16'h0001; Bin = 1'b0;
    step();
    A = 16'h7777; B = 16'h1111; step();
    A = 16'h4444; B = 16'h2222; step();
    A = 16'h9999; B = 16'h8888; step();
    A = 16'h3333; B = 16'h0003; step();
    chk("ign_done", {31'd0, Done}, 32'd1);
    chk("ign_d", {16'd0, D}, 32'h000F);
    $display("[TB] ignore-start D=%h Done=%0d", D, Done);
    // Back-to-back: Start in the Done cycle.
    A = 16'h0005; B = 16'h0003; Bin = 1'b0;
    step();
    Start = 1'b0;
    chk("b2b_edge", {30'd0, Busy, Done}, 32'h2);
    step(); step(); step();
    chk("b2b_wait", {30'd0, Busy, Done}, 32'h2);
    step();
    chk("b2b_done", {30'd0, Busy, Done}, 32'h1);
    chk("b2b_d", {16'd0, D}, 32'h0002);
    $display("[TB] back-to-back D=%h", D);
    step();

    // Reset on the second RUN cycle aborts without Done.
    Start = 1'b1; A = 16'hFFFF; B = 16'h0001; Bin = 1'b0;
    step();
    Start = 1'b0;
    step();
    RST = 1'b1;
    step();
    chk("abort_out", {26'd0, Busy, Done, Bout, V, Z, |D}, 32'd0);
    RST = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (Done) seen_done = 1'b1;
    end
    chk("abort_nodone", {31'd0, seen_done}, 32'd0);
    $display("[TB] abort checked");

    run_op("fresh", 16'h5555, 16'h1111, 1'b0, 16'h0000, 16'h4444, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
